gcd_engine: RTL and testbench

Self-contained, parametrised GCD unit that merges the existing GCD datapath and its controller into one block. It computes the greatest common divisor of two unsigned WIDTH-bit operands by repeated subtraction. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake. The unit sits on the team's accelerator bus as a drop-in successor to the fixed 16-bit datapath/controller pair, and adds zero-operand handling and backpressure.

---
 rtl/gcd_engine.sv | 128 ++++++++++++
 tb/tb_gcd_engine.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
// gcd_engine: GCD of two unsigned WIDTH-bit operands by repeated subtraction.
// Operands enter on a valid/ready handshake and the result leaves on another.
// The result is registered and stays on gcd_out until a new one is written.
// Optional build macro GCD_ITER_COUNT_EN builds the subtraction-step counter
// that drives iter_count. Without it, iter_count is tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready high
// BUSY  | one compare/subtract decision per cycle
// DONE  | result on gcd_out with out_valid high, waiting for out_ready
module gcd_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             busy,
  output logic [WIDTH-1:0] iter_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [WIDTH-1:0] res_sel;
  logic             a_zero, b_zero, a_eq_b, a_gt_b;
  logic             done_cond;
  logic             accept, sub_a, sub_b, load_res;

  // Compare results. A zero operand or equal operands end the computation.
  // In all three of those cases the answer is A, except when A is zero.
  assign a_zero    = (a_reg == '0);
  assign b_zero    = (b_reg == '0);
  assign a_eq_b    = (a_reg == b_reg);
  assign a_gt_b    = (a_reg > b_reg);
  assign done_cond = a_zero | b_zero | a_eq_b;
  assign res_sel   = a_zero ? b_reg : a_reg;

  // Each subtraction only runs when its minuend is strictly larger, so it
  // can never underflow.
  assign accept   = (state == IDLE) && in_valid;
  assign load_res = (state == BUSY) && done_cond;
  assign sub_a    = (state == BUSY) && !done_cond && a_gt_b;
  assign sub_b    = (state == BUSY) && !done_cond && !a_gt_b;

  // State register. Reset wins over every handshake input.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (done_cond) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand registers: load on accept, then subtract the smaller from the larger.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= a_in;
      b_reg <= b_in;
    end else if (sub_a) begin
      a_reg <= a_reg - b_reg;
    end else if (sub_b) begin
      b_reg <= b_reg - a_reg;
    end
  end

  // Result register. It is written only on the final BUSY decision, so it
  // holds its value through DONE and after the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst)           res_reg <= '0;
    else if (load_res) res_reg <= res_sel;
  end

  assign gcd_out = res_reg;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_reg;

  // Step counter. The worst case is 2^WIDTH-2 steps, which still fits in
  // WIDTH bits, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst)                 iter_reg <= '0;
    else if (accept)         iter_reg <= '0;
    else if (sub_a || sub_b) iter_reg <= iter_reg + WIDTH'(1);
  end

  assign iter_count = iter_reg;
`else
  assign iter_count = '0;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Testbench for gcd_engine. A 16-bit instance covers the directed and random
// cases, and an 8-bit instance covers the full-range worst case. Results are
// compared against a division-based Euclid model.
module tb_gcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a_in, b_in, gcd_out, iter_count;

  logic        v8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8, g8, it8;

  gcd_engine #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .gcd_out(gcd_out), .busy(busy), .iter_count(iter_count)
  );

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8),
    .a_in(a8), .b_in(b8), .out_valid(ov8), .out_ready(or8),
    .gcd_out(g8), .busy(busy8), .iter_count(it8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Euclid by division. Each division step of quotient q stands for q
  // subtractions, except the last step, which ends on equal operands and
  // so costs one subtraction less.
  function automatic void model(input int unsigned a, input int unsigned b,
                                output int unsigned g, output int unsigned k);
    int unsigned x, y, r;
    k = 0;
    if (a == 0) g = b;
    else if (b == 0) g = a;
    else begin
      x = (a > b) ? a : b;
      y = (a > b) ? b : a;
      while (y != 0) begin
        k += x / y;
        r = x % y;
        x = y;
        y = r;
      end
      g = x;
      k -= 1;
    end
  endfunction

  function automatic int unsigned exp_iter(input int unsigned k);
`ifdef GCD_ITER_COUNT_EN
    return k;
`else
    return 0;
`endif
  endfunction

  // Scoreboard for the 16-bit instance. Inputs change just after posedge,
  // so at negedge they show exactly what the next edge will see.
  int unsigned exp_g[$];
  int unsigned exp_k[$];
  int unsigned obs_log[$];
  int          n_results = 0;

  always @(negedge clk) begin
    int unsigned g, k;
    if (rst) begin
      exp_g.delete();
      exp_k.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_g.size() == 0) check("sb_unexpected_result", out_valid, 0);
        else begin
          g = exp_g.pop_front();
          k = exp_k.pop_front();
          check("sb_gcd", gcd_out, g);
          check("sb_iter", iter_count, exp_iter(k));
          obs_log.push_back(gcd_out);
          n_results++;
        end
      end
      if (in_valid && in_ready) begin
        model(a_in, b_in, g, k);
        exp_g.push_back(g);
        exp_k.push_back(k);
      end
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int cyc = 0;
    while (!in_ready && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit junk, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 70000) begin
      if (junk) begin
        in_valid = 1'b1;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit junk);
    int unsigned g, k;
    int cyc;
    model(a, b, g, k);
    start_op(a, b);
    check("busy_after_accept", busy, 1);
    wait_valid(junk, cyc);
    check("latency", cyc, k + 1);
    check("gcd", gcd_out, g);
    check("iter", iter_count, exp_iter(k));
    @(posedge clk); #1;
    check("in_ready_after_consume", in_ready, 1);
    check("gcd_held_in_idle", gcd_out, g);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    int unsigned g, k;
    int cyc = 0;
    model(a, b, g, k);
    while (!ir8 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    a8 = a; b8 = b; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    cyc = 0;
    while (!ov8 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    check("w8_latency", cyc, k + 1);
    check("w8_gcd", g8, g);
    check("w8_iter", it8, exp_iter(k));
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, base, nlog;
    int unsigned pa[3];
    int unsigned pb[3];
    int unsigned ra, rb;
    bit acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    v8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_gcd", gcd_out, 0);
    check("rst_iter", iter_count, 0);

    // Directed cases: basic result, zero operands, equal operands.
    run_op(16'd12, 16'd8, 1'b0);
    run_op(16'd0, 16'd5, 1'b0);
    run_op(16'd7, 16'd0, 1'b0);
    run_op(16'd0, 16'd0, 1'b0);
    run_op(16'd9, 16'd9, 1'b1);

    // Backpressure: the result is held, and new requests are ignored.
    out_ready = 1'b0;
    start_op(16'd48, 16'd18);
    wait_valid(1'b1, cyc);
    check("bp_latency", cyc, 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_gcd", gcd_out, 6);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_gcd", gcd_out, 6);

    // Reset in the middle of BUSY.
    start_op(16'd1000, 16'd3);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_gcd", gcd_out, 0);
    check("abort_iter", iter_count, 0);
    run_op(16'd9, 16'd6, 1'b0);

    // Reset while DONE holds a result that has not been taken.
    out_ready = 1'b0;
    start_op(16'd9, 16'd6);
    wait_valid(1'b0, cyc);
    check("done_hold_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("done_abort_valid", out_valid, 0);
    check("done_abort_gcd", gcd_out, 0);
    check("done_abort_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Back-to-back pairs with in_valid held high.
    pa[0] = 21; pb[0] = 14;
    pa[1] = 17; pb[1] = 5;
    pa[2] = 100; pb[2] = 75;
    base = n_results;
    nlog = obs_log.size();
    for (int i = 0; i < 3; i++) begin
      a_in = 16'(pa[i]); b_in = 16'(pb[i]); in_valid = 1'b1;
      acc = 1'b0; cyc = 0;
      while (!acc && cyc < 1000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1; cyc++;
      end
    end
    in_valid = 1'b0;
    cyc = 0;
    while (exp_g.size() != 0 && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
    end
    check("b2b_count", n_results - base, 3);
    check("b2b_log_size", obs_log.size() - nlog, 3);
    if (obs_log.size() - nlog == 3) begin
      check("b2b_r0", obs_log[nlog], 7);
      check("b2b_r1", obs_log[nlog + 1], 1);
      check("b2b_r2", obs_log[nlog + 2], 25);
    end

    // Random operand pairs, small enough to keep the latency short.
    for (int i = 0; i < 25; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
      run_op(16'(ra), 16'(rb), 1'($urandom_range(0, 1)));
    end

    // 8-bit instance: the worst case in both operand orders, then random pairs.
    run8(8'd1, 8'd255);
    run8(8'd255, 8'd1);
    run8(8'd12, 8'd8);
    for (int i = 0; i < 8; i++) begin
      run8(8'($urandom), 8'($urandom));
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
